// File: rtl/serpent_cache_pkg.sv
// serpent_cache_pkg: dcache geometry constants shared by the dcache blocks.
package serpent_cache_pkg;
    localparam int unsigned DCACHE_TAG_WIDTH    = 32;
    localparam int unsigned DCACHE_CL_IDX_WIDTH = 8;
    localparam int unsigned DCACHE_OFFSET_WIDTH = 4;
    localparam int unsigned DCACHE_SET_ASSOC    = 4;
    localparam int unsigned DCACHE_NUM_RD_PORTS = 3;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/serpent_rr_arb.sv
// serpent_rr_arb: combinational round-robin pick, first request at or after ptr_i with wrap.
module serpent_rr_arb
    import serpent_cache_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0]        req_i,
    input  logic [idx_w(N)-1:0] ptr_i,
    output logic [N-1:0]        gnt_o,
    output logic [idx_w(N)-1:0] idx_o
);
    localparam int unsigned IdxW = idx_w(N);

    // Scanning downward lets the closest candidate to ptr_i overwrite the others.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[(int'(ptr_i) + i) % N]) idx_o = IdxW'((int'(ptr_i) + i) % N);
        end
    end

    assign gnt_o = (|req_i) ? (N'(1) << idx_o) : '0;
endmodule

// File: rtl/serpent_dcache_rd_arb.sv
// serpent_dcache_rd_arb: round-robin sharing of the dcache read port with a
// late tag phase and broadcast read return.
module serpent_dcache_rd_arb
    import serpent_cache_pkg::*;
#(
    parameter int unsigned NumPorts = DCACHE_NUM_RD_PORTS
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumPorts-1:0]            rd_req_i,
    input  logic [DCACHE_TAG_WIDTH-1:0]    rd_tag_i [NumPorts],
    input  logic [DCACHE_CL_IDX_WIDTH-1:0] rd_idx_i [NumPorts],
    input  logic [DCACHE_OFFSET_WIDTH-1:0] rd_off_i [NumPorts],
    input  logic [NumPorts-1:0]            rd_tag_only_i,
    output logic [NumPorts-1:0]            rd_ack_o,
    output logic [63:0]                    rd_data_o,
    output logic [DCACHE_SET_ASSOC-1:0]    rd_vld_bits_o,
    output logic [DCACHE_SET_ASSOC-1:0]    rd_hit_oh_o,
    output logic                           mem_rd_req_o,
    input  logic                           mem_rd_ack_i,
    output logic [DCACHE_TAG_WIDTH-1:0]    mem_rd_tag_o,
    output logic [DCACHE_CL_IDX_WIDTH-1:0] mem_rd_idx_o,
    output logic [DCACHE_OFFSET_WIDTH-1:0] mem_rd_off_o,
    output logic                           mem_rd_tag_only_o,
    input  logic [63:0]                    mem_rd_data_i,
    input  logic [DCACHE_SET_ASSOC-1:0]    mem_rd_vld_bits_i,
    input  logic [DCACHE_SET_ASSOC-1:0]    mem_rd_hit_oh_i
);
    localparam int unsigned IdxW = idx_w(NumPorts);

    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d, last_win_q, last_win_d, win;
    logic [NumPorts-1:0] gnt;
    logic                ack;

    serpent_rr_arb #(.N(NumPorts)) i_rr_arb (
        .req_i (rd_req_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (win)
    );

    assign mem_rd_req_o      = rst_ni & (|rd_req_i);
    assign ack               = mem_rd_ack_i & mem_rd_req_o;
    assign rd_ack_o          = ack ? gnt : '0;
    assign mem_rd_idx_o      = mem_rd_req_o ? rd_idx_i[win] : '0;
    assign mem_rd_off_o      = mem_rd_req_o ? rd_off_i[win] : '0;
    assign mem_rd_tag_only_o = mem_rd_req_o & rd_tag_only_i[win];
    // Tag of the port acked last cycle, matching the memory's late-tag protocol.
    assign mem_rd_tag_o      = rd_tag_i[last_win_q];

    assign rd_data_o     = mem_rd_data_i;
    assign rd_vld_bits_o = mem_rd_vld_bits_i;
    assign rd_hit_oh_o   = mem_rd_hit_oh_i;

    always_comb begin
        rr_ptr_d   = ack ? ((win == IdxW'(NumPorts - 1)) ? '0 : win + 1'b1) : rr_ptr_q;
        last_win_d = ack ? win : last_win_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            last_win_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            last_win_q <= last_win_d;
        end
    end
endmodule

// File: tb/tb_serpent_dcache_rd_arb.sv
// tb_serpent_dcache_rd_arb: directed checks of arbitration, late tag, return path and reset.
module tb_serpent_dcache_rd_arb;
    import serpent_cache_pkg::*;

    logic                           clk_i = 1'b0;
    logic                           rst_ni;
    logic [2:0]                     rd_req_i;
    logic [DCACHE_TAG_WIDTH-1:0]    rd_tag_i [3];
    logic [DCACHE_CL_IDX_WIDTH-1:0] rd_idx_i [3];
    logic [DCACHE_OFFSET_WIDTH-1:0] rd_off_i [3];
    logic [2:0]                     rd_tag_only_i;
    logic [2:0]                     rd_ack_o;
    logic [63:0]                    rd_data_o;
    logic [DCACHE_SET_ASSOC-1:0]    rd_vld_bits_o, rd_hit_oh_o;
    logic                           mem_rd_req_o, mem_rd_ack_i, mem_rd_tag_only_o;
    logic [DCACHE_TAG_WIDTH-1:0]    mem_rd_tag_o;
    logic [DCACHE_CL_IDX_WIDTH-1:0] mem_rd_idx_o;
    logic [DCACHE_OFFSET_WIDTH-1:0] mem_rd_off_o;
    logic [63:0]                    mem_rd_data_i;
    logic [DCACHE_SET_ASSOC-1:0]    mem_rd_vld_bits_i, mem_rd_hit_oh_i;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    serpent_dcache_rd_arb #(.NumPorts(3)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .rd_req_i          (rd_req_i),
        .rd_tag_i          (rd_tag_i),
        .rd_idx_i          (rd_idx_i),
        .rd_off_i          (rd_off_i),
        .rd_tag_only_i     (rd_tag_only_i),
        .rd_ack_o          (rd_ack_o),
        .rd_data_o         (rd_data_o),
        .rd_vld_bits_o     (rd_vld_bits_o),
        .rd_hit_oh_o       (rd_hit_oh_o),
        .mem_rd_req_o      (mem_rd_req_o),
        .mem_rd_ack_i      (mem_rd_ack_i),
        .mem_rd_tag_o      (mem_rd_tag_o),
        .mem_rd_idx_o      (mem_rd_idx_o),
        .mem_rd_off_o      (mem_rd_off_o),
        .mem_rd_tag_only_o (mem_rd_tag_only_o),
        .mem_rd_data_i     (mem_rd_data_i),
        .mem_rd_vld_bits_i (mem_rd_vld_bits_i),
        .mem_rd_hit_oh_i   (mem_rd_hit_oh_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        rd_tag_i          = '{32'h0000_AAAA, 32'h0000_1111, 32'h0000_5555};
        rd_idx_i          = '{8'h10, 8'h2A, 8'h30};
        rd_off_i          = '{4'h1, 4'h8, 4'hF};
        rd_tag_only_i     = 3'b010;
        mem_rd_data_i     = 64'hDEAD_BEEF_0123_4567;
        mem_rd_vld_bits_i = 4'b1011;
        mem_rd_hit_oh_i   = 4'b0100;
        rst_ni            = 1'b0;
        rd_req_i          = 3'b111;
        mem_rd_ack_i      = 1'b1;
        #2;
        chk("reset_ack", 64'(rd_ack_o), 64'(3'b000));
        chk("reset_req", 64'(mem_rd_req_o), 64'(1'b0));
        tick();
        tick();
        rst_ni = 1'b1;
        #1;
        chk("ret_data", rd_data_o, 64'hDEAD_BEEF_0123_4567);
        chk("ret_vld", 64'(rd_vld_bits_o), 64'(4'b1011));
        chk("ret_hit", 64'(rd_hit_oh_o), 64'(4'b0100));

        // Round-robin from reset: two full rotations, late tag follows previous winner.
        for (int k = 0; k < 6; k++) begin
            chk("rr_ack", 64'(rd_ack_o), 64'(3'b001 << (k % 3)));
            chk("rr_req", 64'(mem_rd_req_o), 64'(1'b1));
            if (k > 0) chk("rr_tag", 64'(mem_rd_tag_o), 64'(rd_tag_i[(k - 1) % 3]));
            tick();
        end

        // Memory busy: ports 0 and 2 request, no ack for 4 cycles.
        rd_req_i     = 3'b101;
        mem_rd_ack_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("busy_ack", 64'(rd_ack_o), 64'(3'b000));
            chk("busy_req", 64'(mem_rd_req_o), 64'(1'b1));
            chk("busy_idx", 64'(mem_rd_idx_o), 64'(8'h10));
            tick();
        end
        mem_rd_ack_i = 1'b1;
        #1;
        chk("busy_ack5", 64'(rd_ack_o), 64'(3'b001));
        tick();
        // Back-to-back: port2 acked now, tag is still port0's.
        #1;
        chk("b2b_ack", 64'(rd_ack_o), 64'(3'b100));
        chk("b2b_tag1", 64'(mem_rd_tag_o), 64'(32'h0000_AAAA));
        chk("b2b_idx", 64'(mem_rd_idx_o), 64'(8'h30));
        chk("b2b_off", 64'(mem_rd_off_o), 64'(4'hF));
        tick();
        rd_req_i = 3'b000;
        #1;
        chk("b2b_tag2", 64'(mem_rd_tag_o), 64'(32'h0000_5555));
        chk("idle_req", 64'(mem_rd_req_o), 64'(1'b0));
        chk("idle_idx", 64'(mem_rd_idx_o), 64'(8'h00));
        chk("idle_ack", 64'(rd_ack_o), 64'(3'b000));

        // Withdrawal: port1 requests unacked, then drops; port0 acked at once.
        tick();
        rd_req_i     = 3'b010;
        mem_rd_ack_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("wd_ack", 64'(rd_ack_o), 64'(3'b000));
            tick();
        end
        rd_req_i     = 3'b001;
        mem_rd_ack_i = 1'b1;
        #1;
        chk("wd_ack0", 64'(rd_ack_o), 64'(3'b001));
        tick();

        // Single port 1.
        rd_req_i = 3'b010;
        #1;
        chk("sp_ack", 64'(rd_ack_o), 64'(3'b010));
        chk("sp_idx", 64'(mem_rd_idx_o), 64'(8'h2A));
        chk("sp_off", 64'(mem_rd_off_o), 64'(4'h8));
        chk("sp_tonly", 64'(mem_rd_tag_only_o), 64'(1'b1));
        tick();
        rd_req_i = 3'b111;
        #1;
        chk("sp_tag", 64'(mem_rd_tag_o), 64'(32'h0000_1111));
        chk("sp_ptr2", 64'(rd_ack_o), 64'(3'b100));
        tick();
        #1;
        chk("ms_ack0", 64'(rd_ack_o), 64'(3'b001));
        tick();

        // Reset mid-stream with pointer at 1.
        rst_ni = 1'b0;
        #1;
        chk("mr_ack", 64'(rd_ack_o), 64'(3'b000));
        chk("mr_req", 64'(mem_rd_req_o), 64'(1'b0));
        tick();
        rst_ni   = 1'b1;
        rd_req_i = 3'b110;
        #1;
        chk("mr_first", 64'(rd_ack_o), 64'(3'b010));
        tick();
        rd_req_i = 3'b111;
        #1;
        chk("mr_second", 64'(rd_ack_o), 64'(3'b100));
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serpent_dcache_rd_arb.md
Name: serpent_dcache_rd_arb

Overview:
- Shares the single L1 dcache memory read port between NumPorts read requesters, e.g. the load unit and PTW read controllers.
- Performs round-robin arbitration on request index/offset.
- Forwards the granted requester's tag to memory one cycle after the grant, matching the memory's late-tag protocol.
- Broadcasts read data, valid bits and hit vector back to all requesters.

Parameters:
- NumPorts, 3, number of read requesters; legal range 1..8.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- rd_req_i  in  NumPorts  per-port read request
- rd_tag_i  in  NumPorts x DCACHE_TAG_WIDTH  per-port tag, valid one cycle after that port's ack
- rd_idx_i  in  NumPorts x DCACHE_CL_IDX_WIDTH  per-port cache line index
- rd_off_i  in  NumPorts x DCACHE_OFFSET_WIDTH  per-port byte offset
- rd_tag_only_i  in  NumPorts  per-port tag-only read
- rd_ack_o  out  NumPorts  one-hot0 grant/ack
- rd_data_o  out  64  broadcast read data
- rd_vld_bits_o  out  DCACHE_SET_ASSOC  broadcast valid bits
- rd_hit_oh_o  out  DCACHE_SET_ASSOC  broadcast one-hot hit
- mem_rd_req_o  out  1  memory read request
- mem_rd_ack_i  in  1  memory accepted the request (deasserted while the write port owns the memory)
- mem_rd_tag_o  out  DCACHE_TAG_WIDTH  tag for the request acked in the previous cycle
- mem_rd_idx_o  out  DCACHE_CL_IDX_WIDTH  winner index
- mem_rd_off_o  out  DCACHE_OFFSET_WIDTH  winner offset
- mem_rd_tag_only_o  out  1  winner tag_only
- mem_rd_data_i  in  64  memory read data
- mem_rd_vld_bits_i  in  DCACHE_SET_ASSOC  memory valid bits
- mem_rd_hit_oh_i  in  DCACHE_SET_ASSOC  memory hit vector

Behaviour:
- State registers:
  - rr_ptr_q: clog2(NumPorts) bits, reset 0.
  - last_win_q: clog2(NumPorts) bits, reset 0.
  - For NumPorts==1, both registers are constant 0.
- Winner selection (combinational, cycle t): the first asserted rd_req_i at or after rr_ptr_q, searching upward with wrap from NumPorts-1 to 0.
- mem_rd_req_o = |rd_req_i.
- mem_rd_idx_o, mem_rd_off_o and mem_rd_tag_only_o are muxed from the winner. They are '0 when no request is present.
- rd_ack_o[w] = mem_rd_ack_i & mem_rd_req_o & (w==winner). This is a zero-latency ack in the same cycle as the request. At most one bit is set.
- On an acked cycle:
  - rr_ptr_q <= winner+1, wrapping to 0 after NumPorts-1.
  - last_win_q <= winner.
- On an unacked cycle, both registers hold. The same winner is retried if it still requests.
- Late tag: mem_rd_tag_o = rd_tag_i[last_win_q] in every cycle.
  - Correct in cycle t+1 for the ack in cycle t.
  - Don't-care in cycles not following an ack.
- Return path: rd_data_o, rd_vld_bits_o and rd_hit_oh_o pass straight through from mem_*_i, combinationally. Each requester qualifies them with its own registered ack.
- Requests may drop or change in any cycle without an ack. No ordering is owed to unacked requests.
- Fairness: a port holding rd_req_i high is acked within NumPorts acked cycles.
- Back-to-back acks to different ports in t and t+1 are legal:
  - the t+1 tag belongs to the t winner;
  - the t+1 idx/off belong to the t+1 winner.
- Reset (rst_ni==0, sampled on the clock edge):
  - registers go to 0;
  - rd_ack_o and mem_rd_req_o are forced 0 while rst_ni is low;
  - an in-flight tag phase is abandoned.

Decomposition:
- serpent_cache_pkg: DCACHE_* width constants (existing), new constant DCACHE_NUM_RD_PORTS=3.
- Sub-module serpent_rr_arb holds the combinational round-robin pick.
  - Inputs: req vector, pointer.
  - Outputs: onehot grant, binary index.
- The top level holds the registers, muxes and ack gating.

Test Plan:
- Single port: NumPorts=3, port1 asserts rd_req_i with idx=0x2A, off=0x8, mem_rd_ack_i=1.
  - Cycle t: rd_ack_o=3'b010, mem_rd_idx_o=0x2A.
  - Cycle t+1: mem_rd_tag_o equals rd_tag_i[1].
  - rr_ptr_q=2.
- Round-robin: all three ports request continuously, ack always 1, from reset.
  - Ack sequence is 001,010,100,001.
  - No port waits more than 3 acked cycles.
- Memory busy: ports 0 and 2 request; mem_rd_ack_i=0 for 4 cycles, then 1.
  - rd_ack_o=0 for 4 cycles, mem_rd_req_o=1 throughout.
  - Port 0 is acked in the 5th cycle; pointer unchanged before that.
- Back-to-back tag handoff: port0 acked in t, port2 acked in t+1, tags 0xAAAA and 0x5555.
  - t+1: mem_rd_tag_o=0xAAAA.
  - t+2: mem_rd_tag_o=0x5555.
- Request withdrawal: port1 requests without ack for 2 cycles, then drops; port0 then requests with ack=1.
  - port0 is acked immediately.
  - rd_ack_o[1] never asserts.
- Reset mid-stream: during continuous traffic, drive rst_ni low for 1 cycle.
  - rd_ack_o=0 and mem_rd_req_o=0 during reset.
  - After release, first ack goes to the lowest requesting port from pointer 0.
